alu32: RTL and testbench
========================

// Module: alu32
//
// PURPOSE
// - 32-bit ALU: logic ops, add/sub, signed less-than and unsigned modulo, selected by 3-bit ALUop.
// - Single-cycle ops register their result on the next rising clk edge.
// - MOD is multi-cycle and uses an iterative remainder engine.
// - Standalone datapath block, driven directly by a controller or bench; no handshake outputs.
//
// PARAMETERS
// - WIDTH  32  operand/result width (all behaviour below is written for 32)
//
// PORTS
// - clk     in   1   single system clock, rising edge
// - reset   in   1   asynchronous, active-high reset
// - A       in   32  operand A
// - B       in   32  operand B
// - ALUop   in   3   operation select
// - Result  out  32  registered result
//
// BEHAVIOUR
// - Reset (async, high): Result=0, MOD engine to IDLE, internal regs cleared. Held while reset=1.
// - Opcodes:
//   - 000 AND: A & B
//   - 001 OR: A | B
//   - 010 XOR: A ^ B
//   - 011 NOR: ~(A | B)
//   - 100 LT: signed two's-complement A<B gives 32'd1, else 32'd0
//   - 101 ADD: A+B mod 2^32, carry discarded
//   - 110 SUB: A-B mod 2^32, borrow discarded
//   - 111 MOD: A % B, unsigned
// - Ops 000-110: Result <= f(A,B,ALUop) on every rising clk edge. Latency 1 cycle.
//   No flags and no overflow indication.
// - MOD engine states: IDLE -> BUSY -> DONE.
//   - IDLE, ALUop==111: latch A, B and the 32-bit remainder, clear the counter, go to BUSY.
//   - BUSY: one restoring-division step per cycle, MSB first (shift remainder, subtract B if it fits).
//     After 32 steps, go to DONE.
//   - DONE: Result <= remainder. Stay in DONE while ALUop==111 and A, B are unchanged.
//   - Restart: if ALUop stays 111 but A or B differs from the latched values, restart (go to BUSY).
//   - Abort: ALUop leaving 111 sends the engine to IDLE at once. Normal ops resume next edge.
// - MOD timing:
//   - Result holds its previous value while BUSY.
//   - Final value appears at most 34 cycles after ALUop=111 is first sampled.
// - MOD by zero (B==0): Result=A. No trap.
// - MOD with A<B: Result=A.
// - Reset mid-MOD: abort immediately. Result=0, state IDLE.
// - Inputs are sampled only on clk edges; there is no combinational path to Result.
//
// STRUCTURE
// - Shared package: ALUop encodings
//   - OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NOR=3'b011
//   - OP_LT=3'b100, OP_ADD=3'b101, OP_SUB=3'b110, OP_MOD=3'b111
// - Shared package: MOD state enum IDLE/BUSY/DONE.
// - Sub-module mod_unit (clk, reset, start, a, b, busy, done, rem): holds the iterative remainder FSM.
// - Top level: combinational op mux plus the Result register, with mod_unit rem selected for OP_MOD.
//
// TESTING
// - reset=1 for 100ns, any inputs -> Result==0. Release, then ALUop=000, A=0xC, B=0xA -> Result==0x8.
// - Logic ops, A=0xC, B=0xA, one cycle each:
//   OR -> 0xE; XOR -> 0x6; NOR -> 0xFFFFFFF1.
// - ADD and SUB:
//   - ADD 12+10 -> 22
//   - SUB 12-10 -> 2
//   - ADD 0xFFFFFFFF+1 -> 0
//   - SUB 0-1 -> 0xFFFFFFFF
// - LT:
//   - 15<10 -> 0
//   - 1<10 -> 1
//   - 0xFFFFFFFF(-1)<1 -> 1 (signed)
//   - 5<5 -> 0
// - MOD, wait 40 cycles each:
//   - 78%45 -> 33
//   - 15%4 -> 3
//   - 5%3 -> 2
//   - 7%0 -> 7
//   - 3%9 -> 3
// - Interruptions:
//   - Change B during MOD BUSY -> result is for the new B.
//   - Assert reset mid-MOD -> Result==0 immediately.
//   - Then ADD -> correct sum after 1 cycle.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 datapath: opcode encodings and the
// remainder engine state type.
package alu32_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_LT  = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mod_state_e;

endpackage

// File: rtl/mod_unit.sv
// Iterative unsigned remainder engine: one restoring-division step per cycle,
// MSB first, restarting whenever the operands change while start is held.
module mod_unit
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = $clog2(WIDTH);

  mod_state_e       state, state_n;
  logic [WIDTH-1:0] la, lb, dvd;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted, trial;
  logic             fits, changed, load, step;

  assign changed = (a != la) || (b != lb);
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, lb};
  assign fits    = shifted >= {1'b0, lb};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!start) begin
          state_n = IDLE;
        end else if (changed) begin
          load = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt == CW'(WIDTH - 1)) state_n = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_n = IDLE;
        end else if (changed) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      la    <= '0;
      lb    <= '0;
      dvd   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        la  <= a;
        lb  <= b;
        dvd <= a;
        rem <= '0;
        cnt <= '0;
      end else if (step) begin
        // With lb==0 every step "fits", so the dividend shifts through unchanged: rem ends as a.
        rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd <= dvd << 1;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state == BUSY);
  // Only report completion for the operands currently presented.
  assign done = (state == DONE) && start && !changed;

endmodule

// File: rtl/alu32.sv
// 32-bit ALU with a registered result; MOD is served by the multi-cycle
// mod_unit and Result holds its value until the remainder is ready.
module alu32
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] Result
);

  alu_op_e          op;
  logic [WIDTH-1:0] nxt, mod_rem;
  logic             mod_busy, mod_done, lt;

  assign op = alu_op_e'(ALUop);
  assign lt = $signed(A) < $signed(B);

  mod_unit #(.WIDTH(WIDTH)) u_mod (
    .clk   (clk),
    .reset (reset),
    .start (op == OP_MOD),
    .a     (A),
    .b     (B),
    .busy  (mod_busy),
    .done  (mod_done),
    .rem   (mod_rem)
  );

  always_comb begin
    nxt = Result;
    case (op)
      OP_AND: nxt = A & B;
      OP_OR:  nxt = A | B;
      OP_XOR: nxt = A ^ B;
      OP_NOR: nxt = ~(A | B);
      OP_LT:  nxt = {{(WIDTH-1){1'b0}}, lt};
      OP_ADD: nxt = A + B;
      OP_SUB: nxt = A - B;
      OP_MOD: if (mod_done && !mod_busy) nxt = mod_rem;
      default: nxt = Result;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Result <= '0;
    else       Result <= nxt;
  end

endmodule

// File: tb/tb_alu32.sv
// Bench for alu32: directed literal cases plus randomized traffic compared
// each cycle against an arithmetic reference model.
module tb_alu32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, Result;
  logic [2:0]  ALUop;

  int checks = 0;
  int passes = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ALUop  (ALUop),
    .Result (Result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return a + b;
      3'd6: return a - b;
      default: return (b == 0) ? a : (a % b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: Result=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: exact value for single-cycle ops; for MOD the result
  // is the held value until the remainder is due, and must be final 34 cycles on.
  logic [31:0] m_exp = '0, m_held = '0, m_final = '0, m_a = '0, m_b = '0;
  bit          m_exact = 1'b1, m_holdok = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_exp = '0; m_exact = 1'b1; m_cnt = 0;
    end else if (ALUop != 3'd7) begin
      m_exp = ref_op(ALUop, A, B); m_exact = 1'b1; m_cnt = 0;
    end else begin
      if (m_cnt == 0 || A != m_a || B != m_b) begin
        m_holdok = m_exact;
        m_held   = m_exp;
        m_a = A; m_b = B; m_cnt = 1;
      end else begin
        m_cnt++;
      end
      m_final = ref_op(3'd7, m_a, m_b);
      if (m_cnt >= 35) begin
        m_exact = 1'b1; m_exp = m_final;
      end else begin
        m_exact = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_exact) begin
      chk("model", Result, m_exp);
    end else if (m_holdok) begin
      checks++;
      if (Result === m_held || Result === m_final) passes++;
      else $display("FAIL mod_hold: Result=%h expected %h or %h at %0t", Result, m_held, m_final, $time);
    end
  end

  task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    ALUop = op; A = a; B = b;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [31:0] exp);
    apply(op, a, b, n);
    chk(name, Result, exp);
  endtask

  initial begin
    reset = 1'b1;
    A = 32'hDEADBEEF; B = 32'h12345678; ALUop = 3'd5;
    #101;
    chk("reset", Result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #2;

    lit("and", 3'd0, 32'hC, 32'hA, 1, 32'h8);
    lit("or",  3'd1, 32'hC, 32'hA, 1, 32'hE);
    lit("xor", 3'd2, 32'hC, 32'hA, 1, 32'h6);
    lit("nor", 3'd3, 32'hC, 32'hA, 1, 32'hFFFFFFF1);
    lit("add", 3'd5, 32'd12, 32'd10, 1, 32'd22);
    lit("sub", 3'd6, 32'd12, 32'd10, 1, 32'd2);
    lit("add_wrap", 3'd5, 32'hFFFFFFFF, 32'd1, 1, 32'h0);
    lit("sub_wrap", 3'd6, 32'd0, 32'd1, 1, 32'hFFFFFFFF);
    lit("lt_15_10", 3'd4, 32'd15, 32'd10, 1, 32'd0);
    lit("lt_1_10",  3'd4, 32'd1, 32'd10, 1, 32'd1);
    lit("lt_neg",   3'd4, 32'hFFFFFFFF, 32'd1, 1, 32'd1);
    lit("lt_eq",    3'd4, 32'd5, 32'd5, 1, 32'd0);
    lit("mod_78_45", 3'd7, 32'd78, 32'd45, 40, 32'd33);
    lit("mod_15_4",  3'd7, 32'd15, 32'd4, 40, 32'd3);
    lit("mod_5_3",   3'd7, 32'd5, 32'd3, 40, 32'd2);
    lit("mod_7_0",   3'd7, 32'd7, 32'd0, 40, 32'd7);
    lit("mod_3_9",   3'd7, 32'd3, 32'd9, 40, 32'd3);
    lit("mod_big",   3'd7, 32'hFFFFFFFF, 32'd10, 40, 32'd5);

    apply(3'd7, 32'd78, 32'd45, 5);
    lit("mod_new_b", 3'd7, 32'd78, 32'd7, 40, 32'd1);

    apply(3'd7, 32'd1000, 32'd7, 10);
    reset = 1'b1;
    #1;
    chk("reset_mid_mod", Result, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    lit("add_after_reset", 3'd5, 32'd3, 32'd4, 1, 32'd7);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 14) begin
        apply(3'($urandom_range(0, 6)), $urandom, $urandom, 1);
      end else if (r < 19) begin
        logic [31:0] ma, mb;
        ma = (r[0]) ? $urandom : 32'($urandom_range(0, 200));
        case ($urandom_range(0, 3))
          0: mb = 32'd0;
          1: mb = $urandom;
          default: mb = 32'($urandom_range(1, 50));
        endcase
        if ($urandom_range(0, 3) == 0) begin
          apply(3'd7, ma, mb, $urandom_range(1, 30));
          mb = 32'($urandom_range(0, 60));
        end
        apply(3'd7, ma, mb, $urandom_range(1, 40));
      end else begin
        reset = 1'b1;
        #4;
        reset = 1'b0;
        @(posedge clk); #2;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
